// File: rtl/gate_truth_checker.sv
// Sweeps {A,B} = 00..11 into a 2-input gate, samples its output after a settle delay and scores it
// against TRUTH_TABLE. Define GATE_CHK_LOOP_EN to keep re-sweeping while start stays high (adds pass_cnt).
module gate_truth_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
  parameter int          ERR_CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 y_in,
  output logic                 a_out,
  output logic                 b_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef GATE_CHK_LOOP_EN
  output logic [7:0]           pass_cnt,
`endif
  output logic [3:0]           fail_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           ab_q, ab_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [3:0]           mask_q, mask_d;
  logic                 mismatch;
  logic [ERR_CNT_W-1:0] err_upd;
  logic [3:0]           mask_upd;
`ifdef GATE_CHK_LOOP_EN
  logic [7:0]           pcnt_q, pcnt_d;
`endif

  assign mismatch = (y_in != TRUTH_TABLE[idx_q]);
  assign err_upd  = !mismatch ? err_q : ((err_q == '1) ? err_q : err_q + 1'b1);
  assign mask_upd = mismatch ? (mask_q | (4'b0001 << idx_q)) : mask_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
`ifdef GATE_CHK_LOOP_EN
    pcnt_d  = pcnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = 2'd0;
          ab_d    = 2'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          mask_d  = '0;
        end
      end
      S_APPLY: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SAMPLE: begin
        err_d  = err_upd;
        mask_d = mask_upd;
        if (idx_q == 2'd3) begin
`ifdef GATE_CHK_LOOP_EN
          pcnt_d = pcnt_q + 8'd1;
          if (start) begin
            state_d = S_APPLY;
            idx_d   = 2'd0;
            ab_d    = 2'd0;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_upd == '0);
          end
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_upd == '0);
`endif
        end else begin
          state_d = S_APPLY;
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ab_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
`ifdef GATE_CHK_LOOP_EN
      pcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
`ifdef GATE_CHK_LOOP_EN
      pcnt_q  <= pcnt_d;
`endif
    end
  end

  assign a_out     = ab_q[1];
  assign b_out     = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;
`ifdef GATE_CHK_LOOP_EN
  assign pass_cnt  = pcnt_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: default checker (AND, settle 2) against several gate models, plus a settle-0 OR instance.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, start0, y_in, y0;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count, err0;
  logic [3:0] fail_mask, mask0;
  logic       a0, b0, busy0, done0, pass0;
  int         mode;
  int         n_chk = 0;
  int         n_fail = 0;
  int         lat;
  logic       sel;
`ifdef GATE_CHK_LOOP_EN
  logic [7:0] pass_cnt, pass_cnt0;
`endif

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       y_in = a_out & b_out;
      1:       y_in = ~(a_out & b_out);
      default: y_in = 1'b0;
    endcase
  end
  assign y0 = a0 | b0;

  gate_truth_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
`ifdef GATE_CHK_LOOP_EN
    .pass_cnt(pass_cnt),
`endif
    .fail_mask(fail_mask)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0), .TRUTH_TABLE(4'b1110), .ERR_CNT_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0),
`ifdef GATE_CHK_LOOP_EN
    .pass_cnt(pass_cnt0),
`endif
    .fail_mask(mask0)
  );

  logic       cur_done, cur_busy, cur_pass;
  logic [1:0] cur_ab;
  logic [2:0] cur_err;
  logic [3:0] cur_mask;
  assign cur_done = sel ? done0 : done;
  assign cur_busy = sel ? busy0 : busy;
  assign cur_pass = sel ? pass0 : pass;
  assign cur_ab   = sel ? {a0, b0} : {a_out, b_out};
  assign cur_err  = sel ? err0 : err_count;
  assign cur_mask = sel ? mask0 : fail_mask;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulses start on the chosen instance and follows the sweep cycle by cycle.
  // lat returns accept-edge-to-done edges, or -1 if the sweep was reset.
  task automatic run_sweep(input logic use0, input int period, input int repulse_at,
                           input int reset_at, output int lat_o);
    int cyc;
    sel = use0;
    @(negedge clk);
    if (use0) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start  = 1'b0;
    cyc = 1;
    chk_eq("clear_err_on_accept", {29'd0, cur_err}, 32'd0);
    chk_eq("clear_mask_on_accept", {28'd0, cur_mask}, 32'd0);
    chk_eq("done_low_on_accept", {31'd0, cur_done}, 32'd0);
    while (!cur_done && cyc < 100) begin
      start = 1'b0;
      chk_eq("busy_in_sweep", {31'd0, cur_busy}, 32'd1);
      chk_eq("ab_sequence", {30'd0, cur_ab}, 32'((cyc - 1) / period));
      if (cyc == repulse_at) start = 1'b1;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk_eq("async_reset_outputs",
               {20'd0, a_out, b_out, busy, done, pass, err_count, fail_mask}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat_o = -1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk_eq("sweep_finished", {31'd0, cur_done}, 32'd1);
    lat_o = cyc - 1;
  endtask

  task automatic chk_result(input string tag, input int exp_lat, input int l,
                            input logic exp_pass, input logic [2:0] exp_err, input logic [3:0] exp_mask);
    chk_eq({tag, "_latency"}, 32'(l), 32'(exp_lat));
    chk_eq({tag, "_pass"}, {31'd0, cur_pass}, {31'd0, exp_pass});
    chk_eq({tag, "_err"}, {29'd0, cur_err}, {29'd0, exp_err});
    chk_eq({tag, "_mask"}, {28'd0, cur_mask}, {28'd0, exp_mask});
    chk_eq({tag, "_busy_low"}, {31'd0, cur_busy}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    mode   = 0;
    sel    = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset_outputs", {20'd0, a_out, b_out, busy, done, pass, err_count, fail_mask}, 32'd0);
    chk_eq("reset_outputs_s0", {20'd0, a0, b0, busy0, done0, pass0, err0, mask0}, 32'd0);
`ifdef GATE_CHK_LOOP_EN
    chk_eq("reset_pass_cnt", {24'd0, pass_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    mode = 0;
    run_sweep(1'b0, 4, 0, 0, lat);
    chk_result("and_gate", 16, lat, 1'b1, 3'd0, 4'b0000);
    @(negedge clk);
    chk_eq("and_done_holds", {31'd0, done}, 32'd1);

    mode = 1;
    run_sweep(1'b0, 4, 0, 0, lat);
    chk_result("nand_gate", 16, lat, 1'b0, 3'd4, 4'b1111);

    mode = 2;
    run_sweep(1'b0, 4, 0, 0, lat);
    chk_result("stuck0", 16, lat, 1'b0, 3'd1, 4'b1000);
    mode = 0;
    run_sweep(1'b0, 4, 0, 0, lat);
    chk_result("rerun_and", 16, lat, 1'b1, 3'd0, 4'b0000);

    run_sweep(1'b0, 4, 5, 0, lat);
    chk_result("start_ignored", 16, lat, 1'b1, 3'd0, 4'b0000);

    mode = 1;
    run_sweep(1'b0, 4, 0, 9, lat);
    chk_eq("reset_aborts", 32'(lat), 32'hFFFF_FFFF);
    chk_eq("post_reset_idle", {20'd0, a_out, b_out, busy, done, pass, err_count, fail_mask}, 32'd0);
    mode = 0;
    run_sweep(1'b0, 4, 0, 0, lat);
    chk_result("fresh_after_reset", 16, lat, 1'b1, 3'd0, 4'b0000);

    run_sweep(1'b1, 2, 0, 0, lat);
    chk_result("or_settle0", 8, lat, 1'b1, 3'd0, 4'b0000);
    sel = 1'b0;

`ifdef GATE_CHK_LOOP_EN
    begin
      int cyc;
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      while (pass_cnt == 8'd0 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk_eq("loop_first_pass_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk_eq("loop_done", {31'd0, done}, 32'd1);
      chk_eq("loop_err_saturates", {29'd0, err_count}, 32'd7);
      chk_eq("loop_mask", {28'd0, fail_mask}, 32'hF);
      chk_eq("loop_pass_cnt", {24'd0, pass_cnt}, 32'd2);
      chk_eq("loop_pass", {31'd0, pass}, 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
